// File: rtl/ps2_frame_transmitter.sv
`timescale 1ns/1ps
// ps2_frame_transmitter
//
// Serialises one byte per transaction into a PS/2-style frame: start bit (0),
// eight data bits LSB first, optional odd parity bit, stop bit (1). The
// serial clock idles high, is high for the first half of every bit period
// and low for the second half. DATA_OUT only moves at bit boundaries, so it
// is stable across the whole low phase. Every frame is followed by an idle
// gap before the next byte can be accepted.
//
// Build option:
//   PS2_TX_PARITY_EN  defined   -> 11-bit frame with odd parity bit
//                     undefined -> 10-bit frame, no parity logic
//
// Parameters:
//   HALF_DIV    FCLK cycles per serial-clock half period (>= 2)
//   GAP_CYCLES  idle FCLK cycles after each frame
//
// Ports:
//   FCLK      in   system clock, rising edge
//   RST_N     in   asynchronous reset, active low
//   TX_DATA   in   [7:0] byte to send
//   TX_VALID  in   TX_DATA is valid
//   TX_READY  out  byte accepted on this edge if TX_VALID is high
//   TX_BUSY   out  frame or gap in progress (complement of TX_READY)
//   TX_DONE   out  one-cycle pulse on the first cycle after the stop bit
//   CLK_OUT   out  serial clock, idles high
//   DATA_OUT  out  serial data, idles high

module ps2_frame_transmitter #(
  parameter int HALF_DIV   = 2500,
  parameter int GAP_CYCLES = 5000
) (
  input  logic       FCLK,
  input  logic       RST_N,
  input  logic [7:0] TX_DATA,
  input  logic       TX_VALID,
  output logic       TX_READY,
  output logic       TX_BUSY,
  output logic       TX_DONE,
  output logic       CLK_OUT,
  output logic       DATA_OUT
);

  localparam int DIV_W = (HALF_DIV > 2) ? $clog2(HALF_DIV) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef PS2_TX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd3;
`endif
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_GAP    = 3'd5;

  logic [2:0]       state_q,   state_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             phase_q,   phase_d;    // 0: CLK_OUT high half, 1: low half
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [7:0]       data_q,    data_d;

  logic in_frame;
  logic half_end;
  logic bit_end;

  assign in_frame = (state_q == ST_START) || (state_q == ST_DATA) ||
`ifdef PS2_TX_PARITY_EN
                    (state_q == ST_PARITY) ||
`endif
                    (state_q == ST_STOP);

  assign half_end = (div_cnt_q == DIV_LAST);
  // A bit period ends when the low half finishes; the divider and phase
  // then wrap to zero on their own, so each new bit starts with CLK_OUT high.
  assign bit_end  = half_end && phase_q;

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    phase_d   = phase_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    data_d    = data_q;

    if (in_frame) begin
      div_cnt_d = half_end ? '0 : div_cnt_q + DIV_W'(1);
      if (half_end) phase_d = ~phase_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (TX_VALID) begin
          data_d    = TX_DATA;
          state_d   = ST_START;
          div_cnt_d = '0;
          phase_d   = 1'b0;
          bit_cnt_d = '0;
        end
      end
      ST_START: if (bit_end) state_d = ST_DATA;
      ST_DATA: begin
        if (bit_end) begin
          // 3-bit counter wraps 7 -> 0 exactly as DATA is left.
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
`ifdef PS2_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef PS2_TX_PARITY_EN
      ST_PARITY: if (bit_end) state_d = ST_STOP;
`endif
      ST_STOP: begin
        if (bit_end) begin
          state_d   = ST_GAP;
          gap_cnt_d = '0;
        end
      end
      ST_GAP: begin
        // GAP_CYCLES idle cycles plus the TX_DONE cycle.
        if (gap_cnt_q == GAP_LAST) begin
          state_d   = ST_IDLE;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge FCLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      div_cnt_q <= '0;
      phase_q   <= 1'b0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      phase_q   <= phase_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      data_q    <= data_d;
    end
  end

  // Outputs are decoded from registered state only, so reset forces them
  // to their idle values asynchronously.
  assign TX_READY = (state_q == ST_IDLE);
  assign TX_BUSY  = ~TX_READY;
  assign TX_DONE  = (state_q == ST_GAP) && (gap_cnt_q == '0);
  assign CLK_OUT  = in_frame ? ~phase_q : 1'b1;

  always_comb begin
    DATA_OUT = 1'b1;
    case (state_q)
      ST_START:  DATA_OUT = 1'b0;
      ST_DATA:   DATA_OUT = data_q[bit_cnt_q];
`ifdef PS2_TX_PARITY_EN
      ST_PARITY: DATA_OUT = ~(^data_q);
`endif
      default:   DATA_OUT = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_ps2_frame_transmitter.sv
`timescale 1ns/1ps
// Self-checking bench for ps2_frame_transmitter (HALF_DIV=4, GAP_CYCLES=8).
// A detector records every accepted byte with its accept edge into a
// scoreboard; a monitor decodes the serial line by sampling DATA_OUT on each
// falling CLK_OUT and compares frames and timing against a reference model.

module tb_ps2_frame_transmitter;

  localparam int HALF_DIV   = 4;
  localparam int GAP_CYCLES = 8;
`ifdef PS2_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int DONE_LAT  = FRAME_BITS * 2 * HALF_DIV;
  localparam int READY_LAT = DONE_LAT + GAP_CYCLES + 1;
  localparam int BUDGET    = 400;

  logic       FCLK;
  logic       RST_N;
  logic [7:0] TX_DATA;
  logic       TX_VALID;
  logic       TX_READY;
  logic       TX_BUSY;
  logic       TX_DONE;
  logic       CLK_OUT;
  logic       DATA_OUT;

  ps2_frame_transmitter #(.HALF_DIV(HALF_DIV), .GAP_CYCLES(GAP_CYCLES)) dut (
    .FCLK     (FCLK),
    .RST_N    (RST_N),
    .TX_DATA  (TX_DATA),
    .TX_VALID (TX_VALID),
    .TX_READY (TX_READY),
    .TX_BUSY  (TX_BUSY),
    .TX_DONE  (TX_DONE),
    .CLK_OUT  (CLK_OUT),
    .DATA_OUT (DATA_OUT)
  );

  typedef struct {
    logic [7:0] data;
    int         acc;   // FCLK edge index on which the byte was accepted
  } acc_t;

  acc_t sb[$];
  int   n_checks    = 0;
  int   n_fails     = 0;
  int   cyc         = 0;
  int   n_accepted  = 0;
  int   n_frames    = 0;

  initial begin
    FCLK = 1'b0;
    forever #5 FCLK = ~FCLK;
  end

  initial forever begin
    @(posedge FCLK);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference frame in transmission order, bit 0 first on the wire.
  function automatic logic [10:0] model_frame(input logic [7:0] d);
    logic [10:0] f;
    f    = '0;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1 + i] = d[i];
`ifdef PS2_TX_PARITY_EN
    f[9]  = ($countones(d) % 2 == 0);   // odd parity: total ones must be odd
    f[10] = 1'b1;
`else
    f[9]  = 1'b1;
`endif
    return f;
  endfunction

  // Accept detector: inputs are stable from posedge+1 so a negedge sample
  // predicts what the next rising edge will see.
  initial begin
    int start_chk;
    start_chk = -1;
    forever begin
      @(negedge FCLK);
      if (start_chk == cyc) begin
        check("start_bit_clk_high", CLK_OUT, 1);
        check("start_bit_data", DATA_OUT, 0);
        start_chk = -1;
      end
      if (RST_N && TX_VALID && TX_READY) begin
        sb.push_back('{TX_DATA, cyc + 1});
        start_chk = cyc + 1;
        n_accepted++;
      end
    end
  end

  // Serial-line monitor and scoreboard checker.
  initial begin
    logic [10:0] got;
    int   nbits, low_run, done_cnt;
    logic prev_clk, prev_data, prev_ready, cur_valid;
    acc_t cur;
    got = '0; nbits = 0; low_run = 0; done_cnt = 0;
    prev_clk = 1'b1; prev_data = 1'b1; prev_ready = 1'b1; cur_valid = 1'b0;
    cur = '{8'h00, 0};
    forever begin
      @(negedge FCLK);
      if (!RST_N) begin
        check("rst_clk_out", CLK_OUT, 1);
        check("rst_data_out", DATA_OUT, 1);
        check("rst_ready", TX_READY, 1);
        check("rst_busy", TX_BUSY, 0);
        check("rst_done", TX_DONE, 0);
        sb.delete();
        nbits = 0; low_run = 0; done_cnt = 0; cur_valid = 1'b0;
        prev_clk = 1'b1; prev_data = 1'b1; prev_ready = 1'b1;
      end else begin
        check("busy_is_not_ready", TX_BUSY, !TX_READY);
        if (TX_READY) begin
          check("idle_clk_out", CLK_OUT, 1);
          check("idle_data_out", DATA_OUT, 1);
        end
        if (DATA_OUT !== prev_data) check("data_moves_with_clk_high", CLK_OUT, 1);
        if (CLK_OUT === 1'b0) low_run++;
        if (CLK_OUT === 1'b1 && prev_clk === 1'b0) begin
          check("clk_low_length", low_run, HALF_DIV);
          low_run = 0;
        end
        if (CLK_OUT === 1'b0 && prev_clk === 1'b1) begin
          if (nbits == 0) got = '0;
          got[nbits] = DATA_OUT;
          nbits++;
          if (nbits == FRAME_BITS) begin
            nbits = 0;
            check("frame_was_expected", sb.size() != 0, 1);
            if (sb.size() != 0) begin
              cur       = sb.pop_front();
              cur_valid = 1'b1;
              done_cnt  = 0;
              check("frame_bits", got, model_frame(cur.data));
            end
          end
        end
        if (TX_DONE) begin
          check("done_has_frame", cur_valid, 1);
          if (cur_valid) begin
            check("done_latency", cyc - cur.acc, DONE_LAT);
            done_cnt++;
          end
        end
        if (TX_READY && !prev_ready && cur_valid) begin
          check("ready_latency", cyc - cur.acc, READY_LAT);
          check("done_pulse_count", done_cnt, 1);
          cur_valid = 1'b0;
          n_frames++;
        end
        prev_clk   = CLK_OUT;
        prev_data  = DATA_OUT;
        prev_ready = TX_READY;
      end
    end
  end

  // Returns just after the accept edge; TX_VALID is left as the caller set it.
  task automatic wait_accept();
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < BUDGET; k++) begin
      @(negedge FCLK);
      if (TX_READY) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge FCLK);
    #1;
    check("accept_within_budget", ok, 1);
  endtask

  task automatic wait_idle();
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < BUDGET; k++) begin
      @(negedge FCLK);
      if (TX_READY) begin
        ok = 1'b1;
        break;
      end
    end
    check("idle_within_budget", ok, 1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge FCLK);
    #1;
    TX_DATA  = b;
    TX_VALID = 1'b1;
    wait_accept();
    TX_VALID = 1'b0;
  endtask

  initial begin
    logic [7:0] dir_bytes [4];
    int accepted_before;
    dir_bytes[0] = 8'h1C; dir_bytes[1] = 8'h00;
    dir_bytes[2] = 8'hFF; dir_bytes[3] = 8'h01;

    RST_N = 1'b0; TX_VALID = 1'b0; TX_DATA = 8'h00;
    repeat (3) @(negedge FCLK);
    check("reset_ready", TX_READY, 1);
    check("reset_lines", {CLK_OUT, DATA_OUT}, 2'b11);
    @(posedge FCLK);
    #1;
    RST_N = 1'b1;

    // Directed bytes, including parity corner cases.
    for (int i = 0; i < 4; i++) begin
      send_byte(dir_bytes[i]);
      wait_idle();
    end

    // TX_VALID held high across two frames.
    @(posedge FCLK);
    #1;
    TX_DATA  = 8'hAA;
    TX_VALID = 1'b1;
    wait_accept();
    TX_DATA  = 8'h55;
    wait_accept();
    TX_VALID = 1'b0;
    wait_idle();

    // TX_VALID pulsed while busy must be dropped.
    send_byte(8'h3C);
    repeat (20) @(posedge FCLK);
    #1;
    TX_DATA  = 8'hE7;
    TX_VALID = 1'b1;
    @(posedge FCLK);
    #1;
    TX_VALID = 1'b0;
    wait_idle();
    accepted_before = n_accepted;
    repeat (READY_LAT + 5) @(negedge FCLK);
    check("busy_byte_not_queued", n_accepted - accepted_before, 0);
    check("still_idle", TX_READY, 1);

    // Reset 30 cycles into a frame, during a low serial-clock phase.
    send_byte(8'h5A);
    repeat (30) @(posedge FCLK);
    #1;
    check("pre_reset_clk_low", CLK_OUT, 0);
    TX_DATA  = 8'h96;
    TX_VALID = 1'b1;
    RST_N    = 1'b0;
    #1;
    check("async_rst_clk_out", CLK_OUT, 1);
    check("async_rst_data_out", DATA_OUT, 1);
    check("async_rst_done", TX_DONE, 0);
    check("async_rst_ready", TX_READY, 1);
    repeat (3) @(posedge FCLK);
    #1;
    RST_N = 1'b1;
    wait_accept();
    TX_VALID = 1'b0;
    wait_idle();

    // Randomised bytes with random idle spacing.
    for (int i = 0; i < 16; i++) begin
      repeat ($urandom_range(0, 5)) @(posedge FCLK);
      send_byte(8'($urandom));
      wait_idle();
    end

    repeat (5) @(negedge FCLK);
    check("scoreboard_drained", sb.size(), 0);
    check("frames_completed", n_frames, n_accepted - 1);   // one frame aborted by reset

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/ps2_frame_transmitter.md
PS2_FRAME_TRANSMITTER -- requirements
Module: ps2_frame_transmitter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with the ports named as the codebase names them: FCLK and RST_N.
REQ-002 Parameters SHALL be:
- HALF_DIV, default 2500: FCLK cycles per serial-clock half period; legal values are 2 or more.
- GAP_CYCLES, default 5000: idle FCLK cycles after each frame.
REQ-003 Ports SHALL be:
- FCLK  input  1  system clock; all logic on its rising edge.
- RST_N  input  1  asynchronous reset, active low.
- TX_DATA  input  8  byte to send.
- TX_VALID  input  1  TX_DATA is valid.
- TX_READY  output  1  block will accept a byte this cycle.
- TX_BUSY  output  1  a frame or gap is in progress.
- TX_DONE  output  1  one-cycle pulse when the stop bit completes.
- CLK_OUT  output  1  serial clock; idles high.
- DATA_OUT  output  1  serial data; idles high.

Function
REQ-004 A byte SHALL be accepted on the FCLK edge where TX_VALID=1 and TX_READY=1; TX_DATA SHALL be latched on that edge.
REQ-005 TX_VALID while TX_READY=0 SHALL be ignored; the block SHALL NOT queue it.
REQ-006 FSM states SHALL be IDLE, START, DATA, PARITY, STOP, GAP. Transitions:
- IDLE to START on accept.
- START to DATA after one bit period.
- DATA to PARITY after 8 bit periods.
- PARITY to STOP after one bit period.
- STOP to GAP after one bit period.
- GAP to IDLE after GAP_CYCLES.
REQ-007 Bit period SHALL be 2*HALF_DIV FCLK cycles:
- CLK_OUT high for the first HALF_DIV cycles, low for the second HALF_DIV cycles.
- DATA_OUT changes only at bit-period boundaries, while CLK_OUT is high.
REQ-008 Frame SHALL be: start bit 0; TX_DATA[0] through TX_DATA[7], LSB first; odd parity bit (XOR of the 8 data bits, inverted); stop bit 1.
REQ-009 The start bit SHALL appear on DATA_OUT on the cycle after the accept edge, with CLK_OUT high.
REQ-010 TX_DONE SHALL pulse high for exactly one cycle: the first cycle of GAP.
REQ-011 TX_READY SHALL be 1 only in IDLE; TX_BUSY SHALL be its complement.
REQ-012 In IDLE and GAP, CLK_OUT and DATA_OUT SHALL both be 1.
REQ-013 The bit counter SHALL be 3 bits, wrap from 7 to 0 exactly on the DATA-to-PARITY transition, and never overflow.
REQ-014 The half-period counter SHALL be sized for HALF_DIV and reload to 0 at every half-period boundary.
REQ-015 Accept-to-TX_READY latency SHALL be 22*HALF_DIV + GAP_CYCLES + 1 cycles with parity, and 20*HALF_DIV + GAP_CYCLES + 1 without.
REQ-016 TX_VALID held high continuously SHALL send back-to-back frames, each separated by a full gap.

Reset
REQ-017 While RST_N=0 the block SHALL force asynchronously:
- state = IDLE and all counters = 0;
- CLK_OUT = 1, DATA_OUT = 1;
- TX_READY = 1, TX_BUSY = 0, TX_DONE = 0.
REQ-018 Reset during a frame SHALL abort it immediately, with no TX_DONE pulse; after reset the block SHALL accept a new byte on the first edge with RST_N=1 and TX_VALID=1.

Configuration
REQ-019 The macro PS2_TX_PARITY_EN SHALL select the parity bit:
- Defined: the PARITY state and the parity bit are present, giving an 11-bit frame.
- Undefined: DATA goes directly to STOP, giving a 10-bit frame, and no parity logic is synthesized.

Verification (HALF_DIV=4, GAP_CYCLES=8, macro defined unless noted)
REQ-020 Send 0x1C -> DATA_OUT bits are 0,0,0,1,1,1,0,0,0,0,1; each bit lasts 8 cycles, with CLK_OUT low for cycles 4-7; TX_DONE pulses at cycle 88 after accept.
REQ-021 Send 0x00 -> parity bit = 1. Send 0xFF -> parity bit = 1. Send 0x01 -> parity bit = 0.
REQ-022 TX_VALID held high with 0xAA then 0x55 -> two frames; TX_READY returns high 97 cycles after the first accept; the second frame starts the next cycle.
REQ-023 Pulse TX_VALID while TX_BUSY=1 -> the byte is ignored, and the frame in progress is unchanged.
REQ-024 Assert RST_N=0 at cycle 30 of a frame -> CLK_OUT=1 and DATA_OUT=1 within the same cycle; no TX_DONE; a new frame is sent correctly after release.
REQ-025 Macro undefined, send 0x1C -> 10-bit frame with no parity bit; TX_DONE at cycle 80 after accept.
